// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared types and constants for the SAP-II memory arbiter.
//   state_t        : access sequencer states
//   PORT_A/PORT_B  : requester identities used for SEL and LAST
//   ROM_TOP        : highest write-protected address (monitor ROM)
//   RAM_BASE       : first writable address
package memory_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ROM_TOP  = 16'h07FF;
  localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0800;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // True when the address lies in the write-protected monitor ROM.
  function automatic logic in_rom(input logic [ADDR_W-1:0] addr);
    return addr < RAM_BASE;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin picker.
//   REQ_A, REQ_B : pending requests
//   LAST         : port served most recently (PORT_A / PORT_B)
//   VALID        : at least one request pending
//   WINNER       : port to serve next (meaningful only when VALID)
module rr_pick2
  import memory_arbiter_pkg::*;
(
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic LAST,
  output logic VALID,
  output logic WINNER
);

  always_comb begin
    VALID  = REQ_A | REQ_B;
    WINNER = PORT_A;
    if (REQ_A && REQ_B) begin
      // Contention: whoever was not served last time goes first.
      WINNER = (LAST == PORT_A) ? PORT_B : PORT_A;
    end else if (REQ_B) begin
      WINNER = PORT_B;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the SAP-II 64K memory (2K ROM + 62K RAM) between the CPU port (A)
// and the monitor/loader port (B). Each access runs IDLE -> ACCESS -> DONE.
//   CLK, CLR             : clock, synchronous active-high reset
//   REQ_x/WE_x/ADDR_x/WDATA_x : request, direction, address, write data
//   ACK_A, ACK_B         : one-cycle completion pulse for the served port
//   RDATA                : read result register, valid with ACK
//   ERR                  : write to ROM was suppressed (with ACK)
//   MEM_ADDR, MEM_CE     : memory address and write strobe
//   MEM_DATA             : bidirectional memory data bus
//
// state  | meaning
// IDLE   | no access in progress, arbitrating
// ACCESS | the single memory cycle, address/CE/data on the bus
// DONE   | acknowledge cycle, ACK and ERR presented
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic              WE_A,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_A,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              ACK_A,
  output logic              ACK_B,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_CE,
  inout  wire  [DATA_W-1:0] MEM_DATA
);

  state_t state;
  state_t state_next;

  logic              sel_q;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic pick_valid;
  logic pick_winner;
  logic load_req;
  logic capture_rd;
  logic rom_hit;

  rr_pick2 u_pick (
    .REQ_A  (REQ_A),
    .REQ_B  (REQ_B),
    .LAST   (last_q),
    .VALID  (pick_valid),
    .WINNER (pick_winner)
  );

  assign rom_hit = in_rom(addr_q);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are decoded purely from state so that a CLR arriving in DONE
  // still shows the ACK for that cycle.
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    capture_rd = 1'b0;
    ACK_A      = 1'b0;
    ACK_B      = 1'b0;
    ERR        = 1'b0;
    MEM_ADDR   = '0;
    MEM_CE     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = ACCESS;
          load_req   = 1'b1;
        end
      end
      ACCESS: begin
        state_next = DONE;
        MEM_ADDR   = addr_q;
        MEM_CE     = we_q & ~rom_hit;
        capture_rd = ~we_q;
      end
      DONE: begin
        state_next = IDLE;
        ACK_A      = (sel_q == PORT_A);
        ACK_B      = (sel_q == PORT_B);
        ERR        = we_q & rom_hit;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sel_q   <= PORT_A;
      last_q  <= PORT_B;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (load_req) begin
        sel_q  <= pick_winner;
        last_q <= pick_winner;
        if (pick_winner == PORT_A) begin
          we_q    <= WE_A;
          addr_q  <= ADDR_A;
          wdata_q <= WDATA_A;
        end else begin
          we_q    <= WE_B;
          addr_q  <= ADDR_B;
          wdata_q <= WDATA_B;
        end
      end
      // Memory data settles during ACCESS; sample it on the closing edge.
      if (capture_rd) begin
        rdata_q <= MEM_DATA;
      end
    end
  end

  assign RDATA    = rdata_q;
  assign MEM_DATA = MEM_CE ? wdata_q : {DATA_W{1'bz}};

endmodule
